iq_dispatch: RTL and testbench



---
 rtl/iq_pkg.sv | 85 ++++++++
 rtl/iq_alloc_pick.sv | 42 ++++
 rtl/iq_dispatch.sv | 162 ++++++++++++++++
 tb/tb_iq_dispatch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared definitions for the centralized issue queue: widths, entry field
// positions, port indices and small helpers used by dispatch and issue.
package iq_pkg;

    localparam int OPCODE_WIDTH = 7;
    localparam int PRF_WIDTH    = 6;
    localparam int AGE_WIDTH    = 5;
    localparam int IQ_DEPTH     = 16;
    localparam int IDX_WIDTH    = 4;
    localparam int WB_PORTS     = 4;
    localparam int DISP_WIDTH   = 2;
    localparam int CNT_WIDTH    = 5;

    // Entry field positions, LSB first
    localparam int FREE_BIT     = 0;
    localparam int ISSUED_BIT   = 1;
    localparam int AGE_LSB      = 2;
    localparam int AGE_MSB      = 6;
    localparam int PRDV_BIT     = 7;
    localparam int PRD_LSB      = 8;
    localparam int PRD_MSB      = 13;
    localparam int PRS2_RDY_BIT = 14;
    localparam int PRS2_V_BIT   = 15;
    localparam int PRS2_LSB     = 16;
    localparam int PRS2_MSB     = 21;
    localparam int PRS1_RDY_BIT = 22;
    localparam int PRS1_V_BIT   = 23;
    localparam int PRS1_LSB     = 24;
    localparam int PRS1_MSB     = 29;
    localparam int OP_LSB       = 30;
    localparam int OP_MSB       = 36;
    localparam int IQ_WIDTH     = OP_MSB + 1;

    // Wakeup / issue port indices
    localparam int ALU0 = 0;
    localparam int ALU1 = 1;
    localparam int MUL  = 2;
    localparam int LS   = 3;

    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] op;
        logic [PRF_WIDTH-1:0]    prs1;
        logic                    prs1V;
        logic                    prs1Rdy;
        logic [PRF_WIDTH-1:0]    prs2;
        logic                    prs2V;
        logic                    prs2Rdy;
        logic [PRF_WIDTH-1:0]    prd;
        logic                    prdV;
        logic [AGE_WIDTH-1:0]    age;
        logic                    issued;
        logic                    free;
    } iq_entry_t;

    localparam iq_entry_t ENTRY_RESET = '{free: 1'b1, default: '0};

    // True when any valid writeback port broadcasts the given tag
    function automatic logic wbHit(
        input logic [PRF_WIDTH-1:0]          tag,
        input logic [WB_PORTS-1:0]           wbValid,
        input logic [WB_PORTS*PRF_WIDTH-1:0] wbPrd
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wbValid[k] && (wbPrd[k*PRF_WIDTH +: PRF_WIDTH] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Age plus the number dispatched this cycle, pinned at the maximum
    function automatic logic [AGE_WIDTH-1:0] ageAdd(
        input logic [AGE_WIDTH-1:0] age,
        input logic [1:0]           n
    );
        logic [AGE_WIDTH:0] sum;
        sum = {1'b0, age} + (AGE_WIDTH+1)'(n);
        return sum[AGE_WIDTH] ? AGE_MAX : sum[AGE_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/iq_alloc_pick.sv
// Finds the two lowest-index zero bits of the occupancy vector, i.e. the two
// lowest free queue entries, for dispatch allocation.
module iq_alloc_pick
    import iq_pkg::*;
(
    input  logic [IQ_DEPTH-1:0]  busy_i,
    output logic [IDX_WIDTH-1:0] idx0_o,
    output logic [IDX_WIDTH-1:0] idx1_o,
    output logic                 valid0_o,
    output logic                 valid1_o
);

    logic [IDX_WIDTH-1:0] idx0;
    logic [IDX_WIDTH-1:0] idx1;
    logic                 found0;
    logic                 found1;

    // Priority scan from entry 0 upward, first hit goes to idx0, second to idx1
    always_comb begin
        idx0   = '0;
        idx1   = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (!busy_i[i]) begin
                if (!found0) begin
                    idx0   = IDX_WIDTH'(i);
                    found0 = 1'b1;
                end else if (!found1) begin
                    idx1   = IDX_WIDTH'(i);
                    found1 = 1'b1;
                end
            end
        end
    end

    assign idx0_o   = idx0;
    assign idx1_o   = idx1;
    assign valid0_o = found0;
    assign valid1_o = found1;

endmodule

// File: rtl/iq_dispatch.sv
// Dispatch-side owner of the centralized issue queue: allocates entries for
// up to two renamed micro-ops per cycle, stamps relative age, tracks source
// wakeup and releases entries granted by the issue stage.
module iq_dispatch
    import iq_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [DISP_WIDTH-1:0]            disp_valid,
    output logic                             disp_ready,
    input  logic [DISP_WIDTH*OPCODE_WIDTH-1:0] disp_op,
    input  logic [DISP_WIDTH*PRF_WIDTH-1:0]  disp_prs1,
    input  logic [DISP_WIDTH*PRF_WIDTH-1:0]  disp_prs2,
    input  logic [DISP_WIDTH*PRF_WIDTH-1:0]  disp_prd,
    input  logic [DISP_WIDTH-1:0]            disp_prs1_v,
    input  logic [DISP_WIDTH-1:0]            disp_prs2_v,
    input  logic [DISP_WIDTH-1:0]            disp_prd_v,
    input  logic [DISP_WIDTH-1:0]            disp_prs1_rdy,
    input  logic [DISP_WIDTH-1:0]            disp_prs2_rdy,
    input  logic [WB_PORTS-1:0]              wb_valid,
    input  logic [WB_PORTS*PRF_WIDTH-1:0]    wb_prd,
    input  logic [WB_PORTS-1:0]              iss_grant,
    input  logic [WB_PORTS*IDX_WIDTH-1:0]    iss_addr,
    output logic [IQ_DEPTH*IQ_WIDTH-1:0]     ciq,
    output logic [CNT_WIDTH-1:0]             free_cnt
);

    iq_entry_t            entries_q [IQ_DEPTH];
    iq_entry_t            entries_d [IQ_DEPTH];
    logic [CNT_WIDTH-1:0] freeCnt_q;
    logic [CNT_WIDTH-1:0] freeCnt_d;

    iq_entry_t            newEnt [DISP_WIDTH];
    logic [IQ_DEPTH-1:0]  busyVec;
    logic [IDX_WIDTH-1:0] pickIdx0;
    logic [IDX_WIDTH-1:0] pickIdx1;
    logic                 pickValid0;
    logic                 pickValid1;
    logic                 take0;
    logic                 take1;
    logic [1:0]           dispCnt;
    logic [IQ_DEPTH-1:0]  grantMask;
    logic [CNT_WIDTH-1:0] grantCnt;

    iq_alloc_pick u_pick (
        .busy_i   (busyVec),
        .idx0_o   (pickIdx0),
        .idx1_o   (pickIdx1),
        .valid0_o (pickValid0),
        .valid1_o (pickValid1)
    );

    // Occupancy vector and the registered queue image seen by the issue stage
    always_comb begin
        busyVec = '0;
        ciq     = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            busyVec[i]                     = ~entries_q[i].free;
            ciq[i*IQ_WIDTH +: IQ_WIDTH]    = entries_q[i];
        end
    end

    assign free_cnt   = freeCnt_q;
    assign disp_ready = (freeCnt_q >= CNT_WIDTH'(2));
    assign take0      = disp_valid[0] & disp_ready & pickValid0;
    assign take1      = disp_valid[1] & disp_ready & pickValid1;
    assign dispCnt    = {1'b0, take0} + {1'b0, take1};

    // Build the incoming entries, folding in same-cycle wakeup as a bypass
    always_comb begin
        for (int s = 0; s < DISP_WIDTH; s++) begin
            newEnt[s]         = '0;
            newEnt[s].op      = disp_op[s*OPCODE_WIDTH +: OPCODE_WIDTH];
            newEnt[s].prs1    = disp_prs1[s*PRF_WIDTH +: PRF_WIDTH];
            newEnt[s].prs2    = disp_prs2[s*PRF_WIDTH +: PRF_WIDTH];
            newEnt[s].prd     = disp_prd[s*PRF_WIDTH +: PRF_WIDTH];
            newEnt[s].prs1V   = disp_prs1_v[s];
            newEnt[s].prs2V   = disp_prs2_v[s];
            newEnt[s].prdV    = disp_prd_v[s];
            newEnt[s].prs1Rdy = ~disp_prs1_v[s] | disp_prs1_rdy[s]
                              | wbHit(disp_prs1[s*PRF_WIDTH +: PRF_WIDTH], wb_valid, wb_prd);
            newEnt[s].prs2Rdy = ~disp_prs2_v[s] | disp_prs2_rdy[s]
                              | wbHit(disp_prs2[s*PRF_WIDTH +: PRF_WIDTH], wb_valid, wb_prd);
        end
        newEnt[0].age = take1 ? AGE_WIDTH'(1) : '0;
    end

    // Next state: grant release, wakeup and aging of held entries, then
    // allocation of free entries; flush overrides everything
    always_comb begin
        entries_d = entries_q;
        grantMask = '0;
        grantCnt  = '0;

        for (int k = 0; k < WB_PORTS; k++) begin
            if (iss_grant[k] && !entries_q[iss_addr[k*IDX_WIDTH +: IDX_WIDTH]].free) begin
                grantMask[iss_addr[k*IDX_WIDTH +: IDX_WIDTH]] = 1'b1;
            end
        end

        for (int i = 0; i < IQ_DEPTH; i++) begin
            grantCnt = grantCnt + CNT_WIDTH'(grantMask[i]);
            if (!entries_q[i].free) begin
                if (entries_q[i].prs1V && wbHit(entries_q[i].prs1, wb_valid, wb_prd)) begin
                    entries_d[i].prs1Rdy = 1'b1;
                end
                if (entries_q[i].prs2V && wbHit(entries_q[i].prs2, wb_valid, wb_prd)) begin
                    entries_d[i].prs2Rdy = 1'b1;
                end
                entries_d[i].age = ageAdd(entries_q[i].age, dispCnt);
                if (grantMask[i]) begin
                    entries_d[i].free   = 1'b1;
                    entries_d[i].issued = 1'b1;
                end
            end
        end

        if (take0) begin
            entries_d[pickIdx0] = newEnt[0];
        end
        if (take1) begin
            entries_d[pickIdx1] = newEnt[1];
        end

        freeCnt_d = freeCnt_q + grantCnt - CNT_WIDTH'(dispCnt);

        if (flush) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                entries_d[i]        = entries_q[i];
                entries_d[i].free   = 1'b1;
                entries_d[i].issued = 1'b0;
            end
            freeCnt_d = CNT_WIDTH'(IQ_DEPTH);
        end
    end

    // Queue state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                entries_q[i] <= ENTRY_RESET;
            end
            freeCnt_q <= CNT_WIDTH'(IQ_DEPTH);
        end else begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            freeCnt_q <= freeCnt_d;
        end
    end

    // The issue stage must only grant entries that are currently occupied
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            for (int k = 0; k < WB_PORTS; k++) begin
                assert (!(iss_grant[k] && entries_q[iss_addr[k*IDX_WIDTH +: IDX_WIDTH]].free));
            end
        end
    end

endmodule

// File: tb/tb_iq_dispatch.sv
// Scoreboard bench for iq_dispatch: the stimulus thread queues hand-computed
// expectations tagged with the cycle they apply to; a monitor thread samples
// the queue image on the falling edge and compares.
module tb_iq_dispatch;
   import iq_pkg::*;

   localparam int K_CNT = 0;
   localparam int K_RDY = 1;
   localparam int K_ENT = 2;

   logic                               clk = 1'b0;
   logic                               rst_n;
   logic                               flush;
   logic [DISP_WIDTH-1:0]              disp_valid;
   logic                               disp_ready;
   logic [DISP_WIDTH*OPCODE_WIDTH-1:0] disp_op;
   logic [DISP_WIDTH*PRF_WIDTH-1:0]    disp_prs1;
   logic [DISP_WIDTH*PRF_WIDTH-1:0]    disp_prs2;
   logic [DISP_WIDTH*PRF_WIDTH-1:0]    disp_prd;
   logic [DISP_WIDTH-1:0]              disp_prs1_v;
   logic [DISP_WIDTH-1:0]              disp_prs2_v;
   logic [DISP_WIDTH-1:0]              disp_prd_v;
   logic [DISP_WIDTH-1:0]              disp_prs1_rdy;
   logic [DISP_WIDTH-1:0]              disp_prs2_rdy;
   logic [WB_PORTS-1:0]                wb_valid;
   logic [WB_PORTS*PRF_WIDTH-1:0]      wb_prd;
   logic [WB_PORTS-1:0]                iss_grant;
   logic [WB_PORTS*IDX_WIDTH-1:0]      iss_addr;
   logic [IQ_DEPTH*IQ_WIDTH-1:0]       ciq;
   logic [CNT_WIDTH-1:0]               free_cnt;

   typedef struct {
      string       name;
      int          cyc;
      int          kind;
      int          idx;
      int          lsb;
      int          width;
      logic [63:0] exp;
   } expect_t;

   expect_t sb[$];
   int      cyc          = 0;
   int      nVectors     = 0;
   int      nMiscompares = 0;

   iq_dispatch dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .disp_valid    (disp_valid),
      .disp_ready    (disp_ready),
      .disp_op       (disp_op),
      .disp_prs1     (disp_prs1),
      .disp_prs2     (disp_prs2),
      .disp_prd      (disp_prd),
      .disp_prs1_v   (disp_prs1_v),
      .disp_prs2_v   (disp_prs2_v),
      .disp_prd_v    (disp_prd_v),
      .disp_prs1_rdy (disp_prs1_rdy),
      .disp_prs2_rdy (disp_prs2_rdy),
      .wb_valid      (wb_valid),
      .wb_prd        (wb_prd),
      .iss_grant     (iss_grant),
      .iss_addr      (iss_addr),
      .ciq           (ciq),
      .free_cnt      (free_cnt)
   );

   // Free-running clock, 10 time units per cycle
   initial forever #5 clk = ~clk;

   // Cycle counter that expectations are tagged against
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] sample(input int kind, input int idx, input int lsb, input int width);
      logic [IQ_DEPTH*IQ_WIDTH-1:0] sh;
      logic [63:0]                  v;
      if (kind == K_CNT) return 64'(free_cnt);
      if (kind == K_RDY) return 64'(disp_ready);
      sh = ciq >> (idx*IQ_WIDTH + lsb);
      v  = sh[63:0];
      return v & ((64'd1 << width) - 64'd1);
   endfunction

   // Queue an expectation for the state visible 'delay' edges from now
   task automatic checkOutput(input string name, input int kind, input int idx, input int lsb,
                              input int width, input logic [63:0] exp, input int delay);
      expect_t e;
      e.name  = name;
      e.cyc   = cyc + delay;
      e.kind  = kind;
      e.idx   = idx;
      e.lsb   = lsb;
      e.width = width;
      e.exp   = exp;
      sb.push_back(e);
   endtask

   // Drive every DUT input to its idle value
   task automatic clearInputs();
      flush         = 1'b0;
      disp_valid    = '0;
      disp_op       = '0;
      disp_prs1     = '0;
      disp_prs2     = '0;
      disp_prd      = '0;
      disp_prs1_v   = '0;
      disp_prs2_v   = '0;
      disp_prd_v    = '0;
      disp_prs1_rdy = '0;
      disp_prs2_rdy = '0;
      wb_valid      = '0;
      wb_prd        = '0;
      iss_grant     = '0;
      iss_addr      = '0;
   endtask

   // Load one dispatch slot with a full micro-op description
   task automatic setSlot(input int s, input logic [6:0] op,
                          input logic [5:0] p1, input logic p1v, input logic p1r,
                          input logic [5:0] p2, input logic p2v, input logic p2r,
                          input logic [5:0] prd, input logic prdv);
      disp_op[s*OPCODE_WIDTH +: OPCODE_WIDTH] = op;
      disp_prs1[s*PRF_WIDTH +: PRF_WIDTH]     = p1;
      disp_prs2[s*PRF_WIDTH +: PRF_WIDTH]     = p2;
      disp_prd[s*PRF_WIDTH +: PRF_WIDTH]      = prd;
      disp_prs1_v[s]   = p1v;
      disp_prs1_rdy[s] = p1r;
      disp_prs2_v[s]   = p2v;
      disp_prs2_rdy[s] = p2r;
      disp_prd_v[s]    = prdv;
   endtask

   // Let the configured inputs be captured by one edge, then return to idle
   task automatic applyStimulus();
      @(posedge clk);
      #2;
      clearInputs();
   endtask

   // Monitor: on each falling edge, compare every expectation that is due
   initial begin
      expect_t     e;
      logic [63:0] act;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = sample(e.kind, e.idx, e.lsb, e.width);
            nVectors++;
            if (act !== e.exp) begin
               nMiscompares++;
               $display("[TB] FAIL %s (entry %0d): got 0x%0h, expected 0x%0h",
                        e.name, e.idx, act, e.exp);
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      expect_t e;
      clearInputs();
      rst_n = 1'b0;
      applyStimulus();
      applyStimulus();
      rst_n = 1'b1;

      nVectors++;
      if (free_cnt !== 5'd16) begin
         nMiscompares++;
         $display("[TB] FAIL direct_rst_free_cnt: got %0d, expected 16", free_cnt);
      end
      nVectors++;
      if (disp_ready !== 1'b1) begin
         nMiscompares++;
         $display("[TB] FAIL direct_rst_ready: got %b, expected 1", disp_ready);
      end

      checkOutput("rst_free_cnt",   K_CNT, 0,  0, 5,        64'd16, 0);
      checkOutput("rst_disp_ready", K_RDY, 0,  0, 1,        64'd1,  0);
      checkOutput("rst_entry",      K_ENT, 0,  0, IQ_WIDTH, 64'd1,  0);
      checkOutput("rst_entry",      K_ENT, 15, 0, IQ_WIDTH, 64'd1,  0);

      // Fill the queue two per cycle
      for (int c = 0; c < 8; c++) begin
         disp_valid = 2'b11;
         setSlot(0, 7'(2*c),   6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'(c), 1'b1);
         setSlot(1, 7'(2*c+1), 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'(c), 1'b1);
         checkOutput("fill_ready",    K_RDY, 0,     0,      1, 64'd1,             0);
         checkOutput("fill_free_cnt", K_CNT, 0,     0,      5, 64'(16-2*(c+1)),   1);
         checkOutput("fill_op",       K_ENT, 2*c,   OP_LSB, 7, 64'(2*c),          1);
         checkOutput("fill_op",       K_ENT, 2*c+1, OP_LSB, 7, 64'(2*c+1),        1);
         applyStimulus();
      end

      nVectors++;
      if (free_cnt !== 5'd0) begin
         nMiscompares++;
         $display("[TB] FAIL direct_full_free_cnt: got %0d, expected 0", free_cnt);
      end
      nVectors++;
      if (disp_ready !== 1'b0) begin
         nMiscompares++;
         $display("[TB] FAIL direct_full_ready: got %b, expected 0", disp_ready);
      end

      checkOutput("full_ready",    K_RDY, 0,  0,            1, 64'd0,  0);
      checkOutput("fill_age",      K_ENT, 0,  AGE_LSB,      5, 64'd15, 0);
      checkOutput("fill_age",      K_ENT, 1,  AGE_LSB,      5, 64'd14, 0);
      checkOutput("fill_age",      K_ENT, 15, AGE_LSB,      5, 64'd0,  0);
      checkOutput("novalid_rdy1",  K_ENT, 5,  PRS1_RDY_BIT, 1, 64'd1,  0);
      checkOutput("novalid_rdy2",  K_ENT, 5,  PRS2_RDY_BIT, 1, 64'd1,  0);

      // Full queue: dispatch is refused, grants free entries 3 and 7
      disp_valid = 2'b11;
      setSlot(0, 7'h70, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
      iss_grant  = 4'b1011;
      iss_addr   = {4'd3, 4'd0, 4'd7, 4'd3};
      checkOutput("grant_free_cnt", K_CNT, 0, 0,       5, 64'd2,  1);
      checkOutput("grant_ready",    K_RDY, 0, 0,       1, 64'd1,  1);
      checkOutput("grant_flags",    K_ENT, 3, 0,       2, 64'd3,  1);
      checkOutput("grant_flags",    K_ENT, 7, 0,       2, 64'd3,  1);
      checkOutput("grant_stale_op", K_ENT, 3, OP_LSB,  7, 64'd3,  1);
      checkOutput("stall_age",      K_ENT, 0, AGE_LSB, 5, 64'd15, 1);
      applyStimulus();

      // Refill lands in the freed holes
      disp_valid = 2'b11;
      setSlot(0, 7'h40, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd1, 1'b1);
      setSlot(1, 7'h41, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd2, 1'b1);
      checkOutput("refill_op",       K_ENT, 3, OP_LSB,  7, 64'h40, 1);
      checkOutput("refill_flags",    K_ENT, 3, 0,       2, 64'd0,  1);
      checkOutput("refill_age",      K_ENT, 3, AGE_LSB, 5, 64'd1,  1);
      checkOutput("refill_op",       K_ENT, 7, OP_LSB,  7, 64'h41, 1);
      checkOutput("refill_age",      K_ENT, 7, AGE_LSB, 5, 64'd0,  1);
      checkOutput("refill_free_cnt", K_CNT, 0, 0,       5, 64'd0,  1);
      checkOutput("refill_old_age",  K_ENT, 0, AGE_LSB, 5, 64'd17, 1);
      applyStimulus();

      // Release entries 0..3
      iss_grant = 4'b1111;
      iss_addr  = {4'd3, 4'd2, 4'd1, 4'd0};
      checkOutput("grant4_free_cnt", K_CNT, 0, 0, 5, 64'd4, 1);
      applyStimulus();

      // Dispatch with same-cycle wakeup bypass on the MUL port
      disp_valid = 2'b11;
      setSlot(0, 7'h11, 6'd5,  1'b1, 1'b0, 6'd9,  1'b1, 1'b0, 6'd20, 1'b1);
      setSlot(1, 7'h12, 6'd12, 1'b1, 1'b1, 6'd13, 1'b1, 1'b0, 6'd21, 1'b1);
      wb_valid = 4'b0100;
      wb_prd   = {6'd0, 6'd5, 6'd0, 6'd13};
      checkOutput("bypass_rdy1",   K_ENT, 0, PRS1_RDY_BIT, 1, 64'd1,  1);
      checkOutput("bypass_rdy2",   K_ENT, 0, PRS2_RDY_BIT, 1, 64'd0,  1);
      checkOutput("bypass_age",    K_ENT, 0, AGE_LSB,      5, 64'd1,  1);
      checkOutput("bypass_op",     K_ENT, 0, OP_LSB,       7, 64'h11, 1);
      checkOutput("bypass_prd",    K_ENT, 0, PRD_LSB,      6, 64'd20, 1);
      checkOutput("busy_rdy1",     K_ENT, 1, PRS1_RDY_BIT, 1, 64'd1,  1);
      checkOutput("invalid_wb",    K_ENT, 1, PRS2_RDY_BIT, 1, 64'd0,  1);
      checkOutput("two_free_cnt",  K_CNT, 0, 0,            5, 64'd2,  1);
      applyStimulus();

      // Non-matching tag leaves the waiting source alone
      wb_valid = 4'b0001;
      wb_prd   = {6'd0, 6'd0, 6'd0, 6'd8};
      checkOutput("tag8_rdy2", K_ENT, 0, PRS2_RDY_BIT, 1, 64'd0, 1);
      applyStimulus();

      // Matching tag wakes it exactly one edge later
      wb_valid = 4'b0010;
      wb_prd   = {6'd0, 6'd0, 6'd9, 6'd0};
      checkOutput("tag9_before",  K_ENT, 0, PRS2_RDY_BIT, 1, 64'd0, 0);
      checkOutput("tag9_after",   K_ENT, 0, PRS2_RDY_BIT, 1, 64'd1, 1);
      checkOutput("tag9_other",   K_ENT, 1, PRS2_RDY_BIT, 1, 64'd0, 1);
      applyStimulus();
      checkOutput("rdy_sticky",   K_ENT, 0, PRS2_RDY_BIT, 1, 64'd1, 1);
      applyStimulus();

      // Flush together with dispatch and a grant
      flush      = 1'b1;
      disp_valid = 2'b11;
      setSlot(0, 7'h55, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
      setSlot(1, 7'h56, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
      iss_grant  = 4'b0001;
      iss_addr   = {12'd0, 4'd5};
      checkOutput("flush_free_cnt", K_CNT, 0, 0, 5, 64'd16, 1);
      checkOutput("flush_ready",    K_RDY, 0, 0, 1, 64'd1,  1);
      checkOutput("flush_flags",    K_ENT, 0, 0, 2, 64'd1,  1);
      checkOutput("flush_flags",    K_ENT, 5, 0, 2, 64'd1,  1);
      checkOutput("flush_flags",    K_ENT, 8, 0, 2, 64'd1,  1);
      applyStimulus();

      // Single dispatch every cycle; entry 0 is held while 1 and 2 recycle
      for (int c = 0; c < 40; c++) begin
         disp_valid = 2'b01;
         setSlot(0, 7'(c), 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
         if (c >= 2) begin
            iss_grant = 4'b0001;
            iss_addr  = {12'd0, ((c % 2) == 0) ? 4'd1 : 4'd2};
         end
         if (c == 2)  checkOutput("recycle_op", K_ENT, 2, OP_LSB, 7, 64'd2, 1);
         if (c == 3)  checkOutput("recycle_op", K_ENT, 1, OP_LSB, 7, 64'd3, 1);
         if (c == 10) checkOutput("sat_age",    K_ENT, 0, AGE_LSB, 5, 64'd10, 1);
         if (c == 30) checkOutput("sat_age",    K_ENT, 0, AGE_LSB, 5, 64'd30, 1);
         if (c >= 31) checkOutput("sat_age",    K_ENT, 0, AGE_LSB, 5, 64'd31, 1);
         if (c == 39) checkOutput("steady_free_cnt", K_CNT, 0, 0, 5, 64'd14, 1);
         applyStimulus();
      end
      checkOutput("held_op", K_ENT, 0, OP_LSB, 7, 64'd0, 0);

      // Drain the scoreboard with a bounded wait
      for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
      @(posedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         nVectors++;
         nMiscompares++;
         $display("[TB] FAIL %s: never sampled, expected 0x%0h", e.name, e.exp);
      end
      $display("[TB] == %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
